// File: rtl/svc_sram_rd_ctrl.sv
// svc_sram_rd_ctrl: credit-based read controller for an asynchronous SRAM.
// Commands drive the SRAM pins for one cycle. Valid and meta travel through
// a fixed-latency shift register that is aligned to the SRAM read latency.
// The returned data is then buffered in a response FIFO.
// Optional macro SVC_SRAM_RD_CTRL_IO_REG_EN adds an input flop on sram_io_rdata
// and one extra pipeline stage (response latency RD_LAT+2 instead of RD_LAT+1).
module svc_sram_rd_ctrl #(
   parameter int SAW        = 19,
   parameter int DW         = 16,
   parameter int MW         = 5,
   parameter int RD_LAT     = 2,
   parameter int RESP_DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           sram_rd_cmd_valid,
   output logic           sram_rd_cmd_ready,
   input  logic [SAW-1:0] sram_rd_cmd_addr,
   input  logic [MW-1:0]  sram_rd_cmd_meta,
   output logic           sram_rd_resp_valid,
   input  logic           sram_rd_resp_ready,
   output logic [DW-1:0]  sram_rd_resp_data,
   output logic [MW-1:0]  sram_rd_resp_meta,
   output logic [SAW-1:0] sram_io_addr,
   output logic           sram_io_ce_n,
   output logic           sram_io_oe_n,
   input  logic [DW-1:0]  sram_io_rdata
);

`ifdef SVC_SRAM_RD_CTRL_IO_REG_EN
   localparam int NSTG = RD_LAT + 1;
`else
   localparam int NSTG = RD_LAT;
`endif
   localparam int CW = $clog2(RESP_DEPTH + 1);
   localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam logic [PW-1:0] PTR_LAST = PW'(RESP_DEPTH - 1);
   localparam logic [CW-1:0] CRED_MAX = CW'(RESP_DEPTH);

   // Credits count in-flight reads plus FIFO entries, so the FIFO can never overflow.
   logic [CW-1:0]      credit_q, credit_d;
   logic [CW-1:0]      fcnt_q, fcnt_d;
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic               rdy_q, rdy_d;
   logic               rv_q, rv_d;
   logic               ce_n_q, ce_n_d;
   logic [SAW-1:0]     addr_q, addr_d;
   logic [NSTG-1:0]    pv_q, pv_d;
   logic [MW-1:0]      pm_q [NSTG];
   logic [MW-1:0]      pm_d [NSTG];
   logic [DW+MW-1:0]   mem_q [RESP_DEPTH];
   logic [DW-1:0]      wr_data_s;
   logic               accept_s, pop_s, push_s;

   assign accept_s = sram_rd_cmd_valid & rdy_q;
   assign pop_s    = rv_q & sram_rd_resp_ready;
   assign push_s   = pv_q[NSTG-1];

`ifdef SVC_SRAM_RD_CTRL_IO_REG_EN
   logic [DW-1:0] rdata_q;

   // Input flop on the SRAM data bus; data only, no reset needed.
   always_ff @(posedge clk) begin
      rdata_q <= sram_io_rdata;
   end

   assign wr_data_s = rdata_q;
`else
   assign wr_data_s = sram_io_rdata;
`endif

   // Next-state logic for credits, FIFO pointers, pin drivers and the meta pipeline.
   always_comb begin
      credit_d = credit_q;
      fcnt_d   = fcnt_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      addr_d   = addr_q;
      ce_n_d   = 1'b1;
      pv_d     = '0;
      for (int i = 0; i < NSTG; i++) begin
         pm_d[i] = pm_q[i];
      end

      case ({accept_s, pop_s})
         2'b10:   credit_d = credit_q + CW'(1);
         2'b01:   credit_d = credit_q - CW'(1);
         default: credit_d = credit_q;
      endcase

      case ({push_s, pop_s})
         2'b10:   fcnt_d = fcnt_q + CW'(1);
         2'b01:   fcnt_d = fcnt_q - CW'(1);
         default: fcnt_d = fcnt_q;
      endcase

      if (push_s) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? PW'(0) : wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? PW'(0) : rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      if (accept_s) begin
         addr_d = sram_rd_cmd_addr;
         ce_n_d = 1'b0;
      end else begin
         addr_d = addr_q;
         ce_n_d = 1'b1;
      end

      pv_d[0] = accept_s;
      pm_d[0] = sram_rd_cmd_meta;
      for (int i = 1; i < NSTG; i++) begin
         pv_d[i] = pv_q[i-1];
         pm_d[i] = pm_q[i-1];
      end

      rdy_d = (credit_d < CRED_MAX);
      rv_d  = (fcnt_d != CW'(0));
   end

   // Control state register with synchronous reset that flushes all in-flight work.
   always_ff @(posedge clk) begin
      if (rst) begin
         credit_q <= CW'(0);
         fcnt_q   <= CW'(0);
         wr_ptr_q <= PW'(0);
         rd_ptr_q <= PW'(0);
         rdy_q    <= 1'b0;
         rv_q     <= 1'b0;
         ce_n_q   <= 1'b1;
         addr_q   <= SAW'(0);
         pv_q     <= '0;
      end else begin
         credit_q <= credit_d;
         fcnt_q   <= fcnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         rdy_q    <= rdy_d;
         rv_q     <= rv_d;
         ce_n_q   <= ce_n_d;
         addr_q   <= addr_d;
         pv_q     <= pv_d;
      end
   end

   // Meta pipeline and FIFO storage hold data only; their validity lives in pv_q/fcnt_q.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NSTG; i++) begin
         pm_q[i] <= pm_d[i];
      end
      if (push_s) begin
         mem_q[wr_ptr_q] <= {wr_data_s, pm_q[NSTG-1]};
      end
   end

   assign sram_rd_cmd_ready  = rdy_q;
   assign sram_rd_resp_valid = rv_q;
   assign sram_rd_resp_data  = mem_q[rd_ptr_q][DW+MW-1:MW];
   assign sram_rd_resp_meta  = mem_q[rd_ptr_q][MW-1:0];
   assign sram_io_addr       = addr_q;
   assign sram_io_ce_n       = ce_n_q;
   assign sram_io_oe_n       = ce_n_q;

endmodule

// File: tb/tb_svc_sram_rd_ctrl.sv
// Bench for svc_sram_rd_ctrl: directed scenarios plus random traffic, compared
// every cycle against a queue-based model of the read controller.
module tb_svc_sram_rd_ctrl;
   localparam int SAW = 19, DW = 16, MW = 5, RD_LAT = 2, DEPTH = 4;
`ifdef SVC_SRAM_RD_CTRL_IO_REG_EN
   localparam int LAT = RD_LAT + 1;
`else
   localparam int LAT = RD_LAT;
`endif

   logic clk = 1'b0, rst = 1'b1;
   logic cmd_valid = 1'b0, cmd_ready, resp_valid, resp_ready = 1'b0;
   logic [SAW-1:0] cmd_addr = '0, io_addr;
   logic [MW-1:0]  cmd_meta = '0, resp_meta;
   logic [DW-1:0]  resp_data, io_rdata = '0;
   logic io_ce_n, io_oe_n;

   int n_total = 0, n_pass = 0;

   svc_sram_rd_ctrl #(.SAW(SAW), .DW(DW), .MW(MW), .RD_LAT(RD_LAT), .RESP_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .sram_rd_cmd_valid(cmd_valid), .sram_rd_cmd_ready(cmd_ready),
      .sram_rd_cmd_addr(cmd_addr), .sram_rd_cmd_meta(cmd_meta),
      .sram_rd_resp_valid(resp_valid), .sram_rd_resp_ready(resp_ready),
      .sram_rd_resp_data(resp_data), .sram_rd_resp_meta(resp_meta),
      .sram_io_addr(io_addr), .sram_io_ce_n(io_ce_n), .sram_io_oe_n(io_oe_n),
      .sram_io_rdata(io_rdata)
   );

   always #5 clk = ~clk;

   // SRAM content: an address-derived pattern, 0x0A000 -> 0xBEEF.
   function automatic logic [DW-1:0] mem_val(input logic [SAW-1:0] a);
      return a[15:0] ^ {a[18:16], 13'd0} ^ 16'h1EEF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
   endtask

   // SRAM model: data is valid only during the one cycle RD_LAT-1 after the enabled address cycle.
   logic            h_v = 1'b0;
   logic [SAW-1:0]  h_a = '0;
   always @(negedge clk) begin
      h_v = !io_ce_n && !io_oe_n;
      h_a = io_addr;
   end
   always @(posedge clk) begin
      #1;
      io_rdata = h_v ? mem_val(h_a) : DW'($urandom);
   end

   // Reference model: in-order queue of responses each with the first cycle it may appear.
   logic [DW-1:0]  q_data[$];
   logic [MW-1:0]  q_meta[$];
   int             q_due[$];
   int             cyc = 0, credits = 0;
   bit             armed = 0, exp_ready = 0, exp_ce_n = 1, exp_v, acc, pop;
   logic [SAW-1:0] exp_addr = '0;

   always @(negedge clk) begin
      cyc++;
      exp_v = (q_due.size() > 0) && (q_due[0] <= cyc);
      if (armed) begin
         chk("cmd_ready", cmd_ready, exp_ready);
         chk("resp_valid", resp_valid, exp_v);
         if (exp_v) begin
            chk("resp_data", resp_data, q_data[0]);
            chk("resp_meta", resp_meta, q_meta[0]);
         end
         chk("io_ce_n", io_ce_n, exp_ce_n);
         chk("io_oe_n", io_oe_n, exp_ce_n);
         chk("io_addr", io_addr, exp_addr);
      end
      if (rst) begin
         q_data.delete(); q_meta.delete(); q_due.delete();
         credits = 0; exp_ready = 0; exp_ce_n = 1; exp_addr = '0; armed = 1;
      end else begin
         acc = cmd_valid && exp_ready;
         pop = exp_v && resp_ready;
         if (pop) begin
            void'(q_data.pop_front()); void'(q_meta.pop_front()); void'(q_due.pop_front());
            credits--;
         end
         if (acc) begin
            q_data.push_back(mem_val(cmd_addr));
            q_meta.push_back(cmd_meta);
            q_due.push_back(cyc + 1 + LAT);
            credits++;
            exp_addr = cmd_addr;
         end
         exp_ce_n  = !acc;
         exp_ready = (credits < DEPTH);
      end
   end

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Single read of 0x0A000/meta 0x17 with literal expectations on pins, latency and data.
   task automatic single_read();
      cmd_valid = 1'b1; cmd_addr = 19'h0A000; cmd_meta = 5'h17; resp_ready = 1'b1;
      step();
      cmd_valid = 1'b0;
      chk("single_io_addr", io_addr, 32'h0A000);
      chk("single_ce_n", io_ce_n, 32'd0);
      chk("single_oe_n", io_oe_n, 32'd0);
      step(LAT - 1);
      chk("single_early_valid", resp_valid, 32'd0);
      step();
      chk("single_valid", resp_valid, 32'd1);
      chk("single_data", resp_data, 32'hBEEF);
      chk("single_meta", resp_meta, 32'h17);
      step(4);
   endtask

   int nacc;
   bit r;

   // Directed scenarios followed by random traffic.
   initial begin
      step(3);
      rst = 1'b0;
      step();
      chk("ready_after_reset", cmd_ready, 32'd1);

      single_read();

      // Burst of four back-to-back reads.
      resp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cmd_valid = 1'b1; cmd_addr = SAW'(32'h10 + i); cmd_meta = MW'(i);
         chk("burst_ready", cmd_ready, 32'd1);
         step();
      end
      cmd_valid = 1'b0;
      step(8);

      // Backpressure: six commands offered while responses are blocked.
      resp_ready = 1'b0; nacc = 0;
      cmd_valid = 1'b1; cmd_addr = 19'h100; cmd_meta = 5'h01;
      for (int i = 0; i < 10 && nacc < 6; i++) begin
         r = cmd_ready;
         step();
         if (r) begin
            nacc++;
            cmd_addr = cmd_addr + 19'd1; cmd_meta = cmd_meta + 5'd1;
         end
      end
      cmd_valid = 1'b0;
      chk("bp_accepted", nacc, 32'd4);
      chk("bp_ready_low", cmd_ready, 32'd0);
      step(3);
      resp_ready = 1'b1;
      step(6);
      chk("bp_ready_back", cmd_ready, 32'd1);

      // Simultaneous handshake and accept with a full credit pool.
      resp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cmd_valid = 1'b1; cmd_addr = SAW'(32'h200 + i); cmd_meta = MW'(i + 8);
         step();
      end
      cmd_valid = 1'b0;
      step(5);
      cmd_valid = 1'b1; cmd_addr = 19'h2AA; cmd_meta = 5'h1A; resp_ready = 1'b1;
      chk("sim_full_ready", cmd_ready, 32'd0);
      step();
      chk("sim_ready_after_pop", cmd_ready, 32'd1);
      step();
      cmd_valid = 1'b0;
      chk("sim_ready_after_both", cmd_ready, 32'd1);
      step(10);

      // Reset with reads in flight.
      for (int i = 0; i < 3; i++) begin
         cmd_valid = 1'b1; cmd_addr = SAW'(32'h300 + i); cmd_meta = MW'(i + 3);
         step();
      end
      cmd_valid = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("rst_no_valid", resp_valid, 32'd0);
         chk("rst_ce_n", io_ce_n, 32'd1);
         step();
      end
      single_read();

      // Random traffic with occasional resets.
      for (int n = 0; n < 600; n++) begin
         r = cmd_ready;
         step();
         rst = ($urandom_range(0, 149) == 0);
         if (!cmd_valid || r) begin
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_addr  = SAW'($urandom);
            cmd_meta  = MW'($urandom);
         end
         resp_ready = ($urandom_range(0, 3) != 0);
      end
      rst = 1'b0; cmd_valid = 1'b0; resp_ready = 1'b1;
      step(12);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/svc_sram_rd_ctrl.md
SVC_SRAM_RD_CTRL -- requirements
Module: svc_sram_rd_ctrl

Interface
REQ-001 SHALL have parameter SAW, default 19, meaning the SRAM word-address width.
REQ-002 SHALL have parameter DW, default 16, meaning the data width.
REQ-003 SHALL have parameter MW, default 5, meaning the opaque metadata width.
REQ-004 SHALL have parameter RD_LAT, default 2, meaning the cycles from address-driving edge to data-sampling edge (legal range 1..8).
REQ-005 SHALL have parameter RESP_DEPTH, default 4, meaning the response FIFO depth (power of two, at least 1).
REQ-006 SHALL have port clk  in  1  clock; the block uses one clock only.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have ports sram_rd_cmd_valid in 1, sram_rd_cmd_ready out 1, sram_rd_cmd_addr in SAW and sram_rd_cmd_meta in MW, forming the read-command channel.
REQ-009 SHALL have ports sram_rd_resp_valid out 1, sram_rd_resp_ready in 1, sram_rd_resp_data out DW and sram_rd_resp_meta out MW, forming the response channel.
REQ-010 SHALL have ports sram_io_addr out SAW, sram_io_ce_n out 1, sram_io_oe_n out 1 and sram_io_rdata in DW, forming the SRAM pins.

Function
REQ-011 SHALL accept a command when sram_rd_cmd_valid and sram_rd_cmd_ready are both high at a rising edge.
REQ-012 SHALL drive sram_rd_cmd_ready = (credit count < RESP_DEPTH), registered, with no combinational path from sram_rd_resp_ready.
REQ-013 SHALL maintain the credit count (0..RESP_DEPTH) as follows: +1 on command accept, -1 on response handshake, unchanged when both occur in the same cycle.
REQ-014 SHALL, on accept at edge E, present sram_io_addr = cmd_addr and sram_io_ce_n = sram_io_oe_n = 0 in the cycle after E, using registered outputs.
REQ-015 SHALL, in any cycle with no accept at the preceding edge, drive sram_io_ce_n = sram_io_oe_n = 1, with sram_io_addr holding its last value.
REQ-016 SHALL carry valid+meta through an RD_LAT-stage shift register, and SHALL write {sram_io_rdata, meta} into the response FIFO when the tail stage is valid, at edge E+RD_LAT.
REQ-017 SHALL give a command accepted at edge E its sram_rd_resp_valid in the cycle after E+RD_LAT, provided no older responses are pending.
REQ-018 SHALL sustain back-to-back accepts at one per cycle while credits are available.
REQ-019 SHALL return responses in command order, with meta returned unmodified.
REQ-020 SHALL keep sram_rd_resp_valid/data/meta stable while sram_rd_resp_ready is low, per the valid/ready rule.
REQ-021 SHALL never overflow the FIFO, because credits bound in-flight reads plus FIFO occupancy to RESP_DEPTH.
REQ-022 SHALL, when RESP_DEPTH < RD_LAT+1, function correctly at reduced throughput.
REQ-023 SHALL treat a response handshake and a FIFO write in the same cycle as both taking effect.

Reset
REQ-024 SHALL, while rst is high, force: sram_rd_cmd_ready=0, sram_rd_resp_valid=0, sram_io_ce_n=1, sram_io_oe_n=1, sram_io_addr=0, credits=0, pipeline valids=0, FIFO empty.
REQ-025 SHALL, on rst asserted mid-operation, discard all in-flight reads and buffered responses without emitting them.
REQ-026 SHALL raise sram_rd_cmd_ready in the first cycle after rst deasserts.
REQ-027 SHALL not reset sram_rd_resp_data or sram_rd_resp_meta, whose values are don't-care while valid is low.

Configuration
REQ-028 SHALL, when macro SVC_SRAM_RD_CTRL_IO_REG_EN is defined, register sram_io_rdata in an input flop before the FIFO and extend the meta pipeline by one stage, making the response latency RD_LAT+2 cycles after the accept edge.
REQ-029 SHALL, when SVC_SRAM_RD_CTRL_IO_REG_EN is undefined, sample sram_io_rdata directly per REQ-016, giving a latency of RD_LAT+1.

Verification
REQ-030 Bench SHALL cover single read (RD_LAT=2): cmd addr=0x0A000, meta=0x17 accepted cycle 0 -> io_addr=0x0A000 with ce_n/oe_n=0 in cycle 1; resp_valid in cycle 3 with model data 0xBEEF and meta 0x17.
REQ-031 Bench SHALL cover burst: 4 back-to-back cmds addr 0x10..0x13 with resp_ready=1 -> ready stays 1; 4 responses on consecutive cycles 3..6, in order, data matching the model.
REQ-032 Bench SHALL cover backpressure: resp_ready=0 with 6 cmds offered -> exactly 4 accepted, ready=0 afterward, resp data held stable; resp_ready=1 -> 4 in-order responses, then ready returns to 1.
REQ-033 Bench SHALL cover simultaneous events: credits=4 with one resp handshake and a pending cmd -> ready=1 next cycle; next accept plus handshake in the same cycle -> credits stay 4.
REQ-034 Bench SHALL cover reset mid-burst: rst high for 1 cycle with 3 reads in flight -> no resp_valid afterward; credits=0; ce_n=oe_n=1; a new read completes with correct latency.
REQ-035 Bench SHALL cover SVC_SRAM_RD_CTRL_IO_REG_EN defined: the REQ-030 stimulus -> resp_valid in cycle 4 with identical data and meta.
